// File: rtl/sse_pkg.sv
// Shared definitions for the single-symbol-error (SSE) code over GF(2^8),
// primitive polynomial 0x15F. Used by the encoder, its GF multiplier and
// the corrector.
package sse_pkg;

  localparam int unsigned SYM_W      = 8;
  localparam int unsigned N_DATA_SYM = 8;
  localparam int unsigned DATA_W     = SYM_W * N_DATA_SYM;
  localparam int unsigned CW_W       = DATA_W + 2 * SYM_W;

  localparam logic [8:0] PRIM_POLY = 9'h15F;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Codeword layout: data symbols, then P0, then P1.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYM_W-1:0]  p0;
    logic [SYM_W-1:0]  p1;
  } codeword_t;

  // Shift-and-add GF(2^8) product, reduced by PRIM_POLY.
  function automatic logic [SYM_W-1:0] gf_mul(logic [SYM_W-1:0] a, logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYM_W-1] ? (SYM_W'(sh << 1) ^ PRIM_POLY[SYM_W-1:0]) : SYM_W'(sh << 1);
    end
    return acc;
  endfunction

  // alpha^e by square-and-multiply; only evaluated at elaboration time.
  function automatic logic [SYM_W-1:0] alpha_pow(logic [7:0] e);
    logic [SYM_W-1:0] r;
    logic [SYM_W-1:0] base;
    r    = 8'h01;
    base = 8'h02;
    for (int unsigned k = 0; k < 8; k++) begin
      if (e[k]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  // Parity-check column coefficients (alpha^25 = E3, alpha^39 = B4, alpha^50 = 24).
  localparam logic [SYM_W-1:0] H0_COEF [N_DATA_SYM] = '{
    alpha_pow(8'd25),  alpha_pow(8'd39),  alpha_pow(8'd63),  alpha_pow(8'd108),
    alpha_pow(8'd141), alpha_pow(8'd184), alpha_pow(8'd215), alpha_pow(8'd230)};

  localparam logic [SYM_W-1:0] H1_COEF [N_DATA_SYM] = '{
    alpha_pow(8'd50),  alpha_pow(8'd78),  alpha_pow(8'd126), alpha_pow(8'd216),
    alpha_pow(8'd27),  alpha_pow(8'd113), alpha_pow(8'd175), alpha_pow(8'd205)};

endpackage

// File: rtl/sse_encoder_if.sv
// Handshake bus of the SSE encoder.
//   in_valid/in_ready/data_in          : data word in (master -> encoder)
//   out_valid/out_ready/codeword_out   : codeword out (encoder -> master)
interface sse_encoder_if;
  import sse_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  codeword_t         codeword_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, codeword_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, codeword_out
  );
endinterface

// File: rtl/sse_gf_mul.sv
// Combinational 8x8 GF(2^8) multiplier (shift-and-add, poly 0x15F).
//   a, b : operands
//   p    : product
module sse_gf_mul
  import sse_pkg::*;
(
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  output logic [SYM_W-1:0] p
);

  always_comb p = gf_mul(a, b);

endmodule

// File: rtl/sse_encoder.sv
// SSE encoder: latches a 64-bit word, folds SYM_PER_CYCLE symbols per cycle
// into two parity accumulators, then presents {data, P0, P1}.
//   clk, rst_n : clock, async active-low reset
//   bus        : sse_encoder_if slave (input and output handshakes)
//   busy       : high whenever the FSM is not idle
module sse_encoder
  import sse_pkg::*;
#(
  parameter int unsigned SYM_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sse_encoder_if.slave bus,
  output logic         busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DATA_SYM - SYM_PER_CYCLE);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYM_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
  logic [DATA_W-1:0] data_q, data_d;
  codeword_t         cw_q, cw_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [SYM_W-1:0] sym   [N_DATA_SYM];
  logic [SYM_W-1:0] prod0 [SYM_PER_CYCLE];
  logic [SYM_W-1:0] prod1 [SYM_PER_CYCLE];
  logic [SYM_W-1:0] fold0, fold1;

  // Split the latched word into symbols, symbol 0 in the MSBs.
  for (genvar i = 0; i < N_DATA_SYM; i++) begin : g_sym
    assign sym[i] = data_q[DATA_W-1-SYM_W*i -: SYM_W];
  end

  // One multiplier pair per symbol folded this cycle.
  for (genvar j = 0; j < SYM_PER_CYCLE; j++) begin : g_fold
    logic [CNT_W-1:0] idx;
    assign idx = cnt_q + CNT_W'(j);
    sse_gf_mul u_mul0 (.a(sym[idx]), .b(H0_COEF[idx]), .p(prod0[j]));
    sse_gf_mul u_mul1 (.a(sym[idx]), .b(H1_COEF[idx]), .p(prod1[j]));
  end

  // XOR tree over this cycle's products.
  always_comb begin
    fold0 = '0;
    fold1 = '0;
    for (int unsigned j = 0; j < SYM_PER_CYCLE; j++) begin
      fold0 = fold0 ^ prod0[j];
      fold1 = fold1 ^ prod1[j];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    data_d      = data_q;
    cw_d        = cw_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d  = bus.data_in;
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc0_d = acc0_q ^ fold0;
        acc1_d = acc1_q ^ fold1;
        cnt_d  = cnt_q + CNT_W'(SYM_PER_CYCLE);
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle loads the output register; valid then holds until taken.
        out_valid_d = 1'b1;
        cw_d        = '{data: data_q, p0: acc0_q, p1: acc1_q};
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc0_q      <= '0;
      acc1_q      <= '0;
      data_q      <= '0;
      cw_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      data_q      <= data_d;
      cw_q        <= cw_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.codeword_out = cw_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_sse_encoder.sv
// Directed testbench for sse_encoder (SYM_PER_CYCLE = 1).
module tb_sse_encoder;
  import sse_pkg::*;

  localparam int unsigned LATENCY = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  sse_encoder_if bus ();

  sse_encoder #(.SYM_PER_CYCLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int h0e [8] = '{25, 39, 63, 108, 141, 184, 215, 230};
  int h1e [8] = '{50, 78, 126, 216, 27, 113, 175, 205};

  // Multiply by alpha modulo x^8+x^6+x^4+x^3+x^2+x+1.
  function automatic logic [7:0] xtime(logic [7:0] x);
    return x[7] ? ({x[6:0], 1'b0} ^ 8'h5F) : {x[6:0], 1'b0};
  endfunction

  // Reference: d_i * alpha^e by stepping the symbol itself e times.
  function automatic logic [79:0] model(logic [63:0] d);
    logic [7:0] p0, p1, t;
    p0 = '0;
    p1 = '0;
    for (int i = 0; i < 8; i++) begin
      t = d[63-8*i -: 8];
      for (int k = 0; k < h0e[i]; k++) t = xtime(t);
      p0 = p0 ^ t;
      t = d[63-8*i -: 8];
      for (int k = 0; k < h1e[i]; k++) t = xtime(t);
      p1 = p1 ^ t;
    end
    return {d, p0, p1};
  endfunction

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word, hold out_ready low for 'hold' cycles in DONE, then take it.
  task automatic send(input logic [63:0] d, input int hold, output logic [79:0] cw);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_before_send", 80'(bus.in_ready), 80'd1);
    bus.data_in   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.data_in  = {$urandom, $urandom};
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 40);
    check("latency", 80'(lat), 80'(LATENCY));
    cw = bus.codeword_out;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.data_in  = {$urandom, $urandom};
      bus.out_ready = 1'b0;
      tick();
      check("hold_valid", 80'(bus.out_valid), 80'd1);
      check("hold_stable", bus.codeword_out, cw);
      check("hold_in_ready", 80'(bus.in_ready), 80'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", 80'(bus.out_valid), 80'd0);
    check("in_ready_back", 80'(bus.in_ready), 80'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] cw, cw_a, cw_b, cw_c;
    logic [63:0] d;
    int ghosts;

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 80'(bus.in_ready), 80'd1);
    check("rst_out_valid", 80'(bus.out_valid), 80'd0);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_codeword", bus.codeword_out, 80'h0);
    rst_n = 1'b1;
    tick();

    send(64'h0, 0, cw);
    check("zero_word", cw, 80'h0);

    send(64'h0100_0000_0000_0000, 0, cw_a);
    check("sym0_one", cw_a, 80'h0100_0000_0000_0000_E324);

    send(64'h0001_0000_0000_0000, 0, cw_b);
    check("sym1_p0", 80'(cw_b[15:8]), 80'hB4);
    check("sym1_model", cw_b, model(64'h0001_0000_0000_0000));

    send(64'h0101_0000_0000_0000, 0, cw_c);
    check("sym01_p0", 80'(cw_c[15:8]), 80'h57);
    check("linearity", cw_c, cw_a ^ cw_b);

    d = 64'h0123_4567_89AB_CDEF;
    send(d, 20, cw);
    check("backpressure_word", cw, model(d));

    // Reset in the middle of CALC: the word must never appear.
    bus.data_in  = 64'hDEAD_BEEF_CAFE_F00D;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check("calc_busy", 80'(busy), 80'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 80'(bus.out_valid), 80'd0);
    check("midrst_busy", 80'(busy), 80'd0);
    check("midrst_in_ready", 80'(bus.in_ready), 80'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ghosts = 0;
    repeat (20) begin
      tick();
      if (bus.out_valid) ghosts++;
    end
    check("no_ghost_word", 80'(ghosts), 80'd0);
    d = 64'hFFFF_FFFF_FFFF_FFFF;
    send(d, 1, cw);
    check("after_reset_word", cw, model(d));

    for (int n = 0; n < 200; n++) begin
      d = {$urandom, $urandom};
      send(d, $urandom_range(0, 3), cw);
      check("random_word", cw, model(d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sse_encoder.md
Name: sse_encoder

Overview:
Single-symbol-error (SSE) Reed-Solomon-style encoder over GF(2^8) with primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (0x15F). It is the write-side counterpart of the SSE corrector. It takes 64-bit data (8 symbols), computes two parity symbols iteratively, and emits an 80-bit codeword. Valid/ready handshakes on input and output.

Parameters:
SYM_PER_CYCLE, 1, data symbols folded into parity per CALC cycle; legal values 1, 2, 4, 8; CALC length = 8/SYM_PER_CYCLE cycles.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_in valid
in_ready  output  1  encoder can accept data
data_in  input  64  symbol i = data_in[63-8i -: 8], i=0..7
out_valid  output  1  codeword_out valid
out_ready  input  1  consumer accepts codeword
codeword_out  output  80  [79:16]=data, [15:8]=P0, [7:0]=P1
busy  output  1  state != IDLE

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n): state=IDLE, cnt=0, acc0=acc1=0, data register=0, out_valid=0, codeword_out=0, busy=0, in_ready=1.
- Code definition (polynomial basis, symbol i at data bits [63-8i -: 8]):
  - H0 exponents = 25, 39, 63, 108, 141, 184, 215, 230.
  - H1 exponents = 50, 78, 126, 216, 27, 113, 175, 205.
  - P0 = XOR_i gfmul(d_i, α^H0[i]); P1 = XOR_i gfmul(d_i, α^H1[i]).
  - Every valid codeword must give a zero syndrome in the corrector.
- FSM IDLE -> CALC -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch data_in, clear acc0/acc1 and cnt, go to CALC.
  - CALC: in_ready=0. Each cycle fold symbols cnt .. cnt+SYM_PER_CYCLE-1 into acc0/acc1, then cnt += SYM_PER_CYCLE. When the last group is folded (cnt == 8-SYM_PER_CYCLE), go to DONE.
  - DONE: out_valid=1. codeword_out = {data, acc0, acc1} is registered and held stable while out_ready=0. On out_ready: out_valid drops next cycle, state returns to IDLE.
- Latency: accept at edge k; out_valid is high after edge k+8/SYM_PER_CYCLE+1, and not earlier.
- Throughput: at most one codeword per (8/SYM_PER_CYCLE + 2) cycles. There is no overlap; in_ready=0 in CALC and DONE.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE. data_in changes outside IDLE have no effect.
- out_valid, once asserted, stays asserted until the handshake. Data and parity do not change meanwhile.
- All-zero data gives all-zero parity. The encoder is linear: encode(a^b) = encode(a)^encode(b).
- rst_n asserted mid-CALC or mid-DONE: immediate return to reset values. The in-flight word is dropped and is never emitted after reset release.
- GF multiply: shift-and-add reduction with 0x15F, purely combinational. The per-cycle critical path is SYM_PER_CYCLE multipliers plus an XOR tree.

Decomposition:
- Package sse_pkg holds:
  - PRIM_POLY = 9'h15F
  - H0_COEF and H1_COEF as 8-entry byte arrays of precomputed α-powers (e.g. α^25=8'hE3, α^39=8'hB4, α^50=8'h24)
  - state enum {IDLE, CALC, DONE}
  - SYM_W = 8, N_DATA_SYM = 8
- Sub-module sse_gf_mul: 8x8 GF(2^8) combinational multiplier. It is instantiated 2*SYM_PER_CYCLE times in the encoder and can be reused by the corrector.

Test Plan:
- Reset then data_in=64'h0, out_ready=1 -> codeword_out=80'h0 after the specified latency; in_ready returns to 1 two cycles later.
- data_in=64'h0100_0000_0000_0000 -> codeword_out = 80'h0100_0000_0000_0000_E324 (P0=α^25=E3, P1=α^50=24).
- data_in=64'h0101_0000_0000_0000 -> P0=8'h57 (E3^B4); check linearity against the single-symbol results.
- Hold out_ready=0 for 20 cycles in DONE while toggling in_valid/data_in -> out_valid stays 1, codeword_out is unchanged, in_ready=0; release out_ready -> exactly one transfer.
- Assert rst_n=0 in CALC cycle 3, then release -> no out_valid ever follows for that word; next encode is correct.
- Random data, 10k words, SYM_PER_CYCLE ∈ {1,2,4,8}, random out_ready backpressure -> a golden model matches. Loop-back through the corrector with zero or one random symbol error injected -> decode_result=0 and data recovered.
